// File: rtl/char_buffer_reader_pkg.sv
// Shared definitions for the decryption char buffer: geometry, RAM placement,
// reader FSM states and the length clamp applied to requested drains.
package char_buffer_reader_pkg;

  localparam int unsigned CHAR_BUF_BASE   = 1500;
  localparam int unsigned CHAR_BUF_ROWS   = 12;
  localparam int unsigned CHAR_BUF_COLS   = 9;
  localparam int unsigned CHAR_BUF_LEN    = CHAR_BUF_ROWS * CHAR_BUF_COLS;
  localparam int unsigned CHAR_BUF_ADDR_W = 12;
  localparam int unsigned CHAR_IDX_W      = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } state_e;

  // Oversized requests silently drain the whole buffer.
  function automatic logic [CHAR_IDX_W-1:0] clamp_len(input logic [CHAR_IDX_W-1:0] cnt,
                                                      input logic [CHAR_IDX_W-1:0] max_len);
    return (cnt > max_len) ? max_len : cnt;
  endfunction

endpackage

// File: rtl/char_buffer_reader_if.sv
// RAM read-port request/grant bus and the char stream towards the sink.
interface char_buffer_reader_if
  import char_buffer_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = CHAR_BUF_ADDR_W
);

  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_q;
  logic [7:0]        char_data;
  logic              char_valid;
  logic              char_ready;
  logic              char_last;

  modport master (
    output mem_req, mem_addr, char_data, char_valid, char_last,
    input  mem_gnt, mem_q, char_ready
  );

  modport slave (
    input  mem_req, mem_addr, char_data, char_valid, char_last,
    output mem_gnt, mem_q, char_ready
  );

endinterface

// File: rtl/char_buffer_reader.sv
// Drains the char buffer from data RAM one word per char and streams the low
// byte of each word to a valid/ready sink. All outputs are registered.
module char_buffer_reader
  import char_buffer_reader_pkg::*;
#(
  parameter int unsigned BASE_ADDR = CHAR_BUF_BASE,
  parameter int unsigned BUF_LEN   = CHAR_BUF_LEN,
  parameter int unsigned ADDR_W    = CHAR_BUF_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CHAR_IDX_W-1:0] char_count,
  output logic                  busy,
  output logic                  done,
  char_buffer_reader_if.master  bus
);

  localparam logic [ADDR_W-1:0]     BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [CHAR_IDX_W-1:0] MAX_LEN = CHAR_IDX_W'(BUF_LEN);

  state_e                state_q, state_d;
  logic [CHAR_IDX_W-1:0] len_q, len_d;
  logic [CHAR_IDX_W-1:0] idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [7:0]            char_data_q, char_data_d;
  logic                  char_valid_q, char_valid_d;
  logic                  char_last_q, char_last_d;

  logic [CHAR_IDX_W-1:0] req_len;
  logic                  last_idx;
  logic                  mem_q_unused;

  assign req_len      = clamp_len(char_count, MAX_LEN);
  assign last_idx     = (idx_q == len_q - CHAR_IDX_W'(1));
  assign mem_q_unused = ^bus.mem_q[31:8];

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    done_d       = 1'b0;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    char_data_d  = char_data_q;
    char_valid_d = char_valid_q;
    char_last_d  = char_last_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (req_len == '0) begin
            state_d = ST_DONE;
          end else begin
            len_d      = req_len;
            idx_d      = '0;
            mem_req_d  = 1'b1;
            mem_addr_d = BASE;
            state_d    = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        char_data_d  = bus.mem_q[7:0];
        char_valid_d = 1'b1;
        char_last_d  = last_idx;
        state_d      = ST_SEND;
      end
      ST_SEND: begin
        if (bus.char_ready) begin
          char_valid_d = 1'b0;
          char_last_d  = 1'b0;
          if (last_idx) begin
            state_d = ST_DONE;
          end else begin
            idx_d      = idx_q + CHAR_IDX_W'(1);
            mem_req_d  = 1'b1;
            mem_addr_d = BASE + ADDR_W'(idx_d);
            state_d    = ST_REQ;
          end
        end
      end
      ST_DONE: begin
        // done is registered off the DONE state, so it lands in the cycle after it
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including a start in the same cycle.
    if (abort) begin
      state_d      = ST_IDLE;
      len_d        = '0;
      idx_d        = '0;
      done_d       = 1'b0;
      mem_req_d    = 1'b0;
      mem_addr_d   = BASE;
      char_data_d  = '0;
      char_valid_d = 1'b0;
      char_last_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= BASE;
      char_data_q  <= '0;
      char_valid_q <= 1'b0;
      char_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      char_data_q  <= char_data_d;
      char_valid_q <= char_valid_d;
      char_last_q  <= char_last_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.char_data  = char_data_q;
  assign bus.char_valid = char_valid_q;
  assign bus.char_last  = char_last_q;

endmodule

// File: tb/tb_char_buffer_reader.sv
// Bench for char_buffer_reader: RAM and sink modelled in the bench, expected
// char/address streams built from RAM contents and the clamped length.
module tb_char_buffer_reader;
  import char_buffer_reader_pkg::*;

  localparam int unsigned BASE   = 1500;
  localparam int unsigned MAXLEN = 108;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [6:0] char_count;
  logic       busy;
  logic       done;

  logic [31:0] ram [0:4095];
  int n_assert = 0;
  int n_fail   = 0;

  char_buffer_reader_if #(.ADDR_W(12)) bus ();

  char_buffer_reader #(.BASE_ADDR(1500), .BUF_LEN(108), .ADDR_W(12)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .char_count (char_count),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: the RAM latches the granted address and answers 1 cycle later;
  // ungranted cycles present junk on mem_q.
  task automatic cyc();
    logic        g;
    logic [11:0] a;
    g = bus.mem_req & bus.mem_gnt;
    a = bus.mem_addr;
    @(posedge clock);
    #1;
    bus.mem_q = g ? ram[a] : $urandom;
    @(negedge clock);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " busy"},       32'(busy),           32'd0);
    chk({tag, " done"},       32'(done),           32'd0);
    chk({tag, " mem_req"},    32'(bus.mem_req),    32'd0);
    chk({tag, " mem_addr"},   32'(bus.mem_addr),   32'(BASE));
    chk({tag, " char_valid"}, 32'(bus.char_valid), 32'd0);
    chk({tag, " char_last"},  32'(bus.char_last),  32'd0);
    chk({tag, " char_data"},  32'(bus.char_data),  32'd0);
  endtask

  // kill: 0 none, 1 abort, 2 async reset, applied once kill_after chars were accepted.
  task automatic run_drain(input string name, input logic [6:0] cnt, input int stall,
                           input bit rtoggle, input int kill, input int kill_after,
                           input bit restart, input bit timing);
    logic [7:0]  exp_q[$];
    logic [11:0] addr_q[$];
    int          len, t, accepted, dones, req_wait, first_req, first_valid, done_t;
    bit          p_req_stall, p_val_stall;
    logic [11:0] p_addr;
    logic [7:0]  p_data;
    logic        p_last;

    len = (int'(cnt) > MAXLEN) ? MAXLEN : int'(cnt);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(ram[BASE + i][7:0]);
      addr_q.push_back(12'(BASE + i));
    end
    accepted = 0; dones = 0; req_wait = 0;
    first_req = -1; first_valid = -1; done_t = -1;
    p_req_stall = 1'b0; p_val_stall = 1'b0;
    p_addr = '0; p_data = '0; p_last = 1'b0;

    char_count = cnt;
    start = 1'b1;
    cyc();
    start = 1'b0;
    t = 1;

    while (t < 3000 && done_t < 0) begin
      if (done) begin
        dones++;
        done_t = t;
      end
      if (bus.mem_req && first_req < 0) first_req = t;
      if (bus.char_valid && first_valid < 0) first_valid = t;
      if (p_req_stall) begin
        chk({name, " req held"},  32'(bus.mem_req),  32'd1);
        chk({name, " addr held"}, 32'(bus.mem_addr), 32'(p_addr));
      end
      if (p_val_stall) begin
        chk({name, " valid held"}, 32'(bus.char_valid), 32'd1);
        chk({name, " data held"},  32'(bus.char_data),  32'(p_data));
        chk({name, " last held"},  32'(bus.char_last),  32'(p_last));
      end

      if (kill != 0 && accepted == kill_after) begin
        if (kill == 1) begin
          abort = 1'b1;
          cyc();
          abort = 1'b0;
          check_idle({name, " abort"});
        end else begin
          reset = 1'b0;
          #1;
          check_idle({name, " async reset"});
          #2;
          reset = 1'b1;
          @(negedge clock);
          check_idle({name, " after reset"});
        end
        for (int k = 0; k < 3; k++) begin
          cyc();
          chk({name, " no done after kill"}, 32'(done), 32'd0);
          chk({name, " idle after kill"},    32'(busy), 32'd0);
        end
        return;
      end

      start      = restart && (t == 5);
      char_count = restart ? 7'd50 : cnt;
      if (stall == 0)       bus.mem_gnt = 1'b1;
      else if (bus.mem_req) bus.mem_gnt = (req_wait >= stall);
      else                  bus.mem_gnt = 1'($urandom);
      if (!rtoggle)            bus.char_ready = 1'b1;
      else if (bus.char_valid) bus.char_ready = t[0];
      else                     bus.char_ready = 1'($urandom);

      if (bus.mem_req) begin
        if (bus.mem_gnt) begin
          if (addr_q.size() == 0) chk({name, " extra read"}, 32'(bus.mem_addr), 32'd0);
          else chk({name, " addr"}, 32'(bus.mem_addr), 32'(addr_q.pop_front()));
          req_wait = 0;
        end else begin
          req_wait++;
        end
      end
      if (bus.char_valid && bus.char_ready) begin
        if (exp_q.size() == 0) begin
          chk({name, " extra char"}, 32'(bus.char_data), 32'd0);
        end else begin
          chk({name, " last"}, 32'(bus.char_last), 32'(exp_q.size() == 1));
          chk({name, " data"}, 32'(bus.char_data), 32'(exp_q.pop_front()));
        end
        if (timing) chk({name, " accept cycle"}, 32'(t), 32'(3 * (accepted + 1)));
        accepted++;
      end

      p_req_stall = bus.mem_req && !bus.mem_gnt;
      p_addr      = bus.mem_addr;
      p_val_stall = bus.char_valid && !bus.char_ready;
      p_data      = bus.char_data;
      p_last      = bus.char_last;
      cyc();
      t++;
    end

    chk({name, " done pulses"},  32'(dones),          32'd1);
    chk({name, " done width"},   32'(done),           32'd0);
    chk({name, " chars left"},   32'(exp_q.size()),   32'd0);
    chk({name, " reads left"},   32'(addr_q.size()),  32'd0);
    chk({name, " chars sent"},   32'(accepted),       32'(len));
    chk({name, " busy at end"},  32'(busy),           32'd0);
    if (timing) begin
      chk({name, " first req"},   32'(first_req),   32'd1);
      chk({name, " first valid"}, 32'(first_valid), 32'd3);
    end
    if (len == 0) begin
      chk({name, " zero done cycle"}, 32'(done_t),      32'd2);
      chk({name, " zero no req"},     32'(first_req),   32'hFFFF_FFFF);
      chk({name, " zero no valid"},   32'(first_valid), 32'hFFFF_FFFF);
    end
  endtask

  initial begin
    logic [6:0] rc;
    logic [31:0] hello;
    reset = 1'b0; start = 1'b0; abort = 1'b0; char_count = '0;
    bus.mem_gnt = 1'b0; bus.char_ready = 1'b0; bus.mem_q = '0;
    for (int i = 0; i < 4096; i++) ram[i] = $urandom;
    hello = 32'h484C_4C4F;
    ram[BASE + 0] = {$urandom_range(0, 255) == 0 ? 24'h0 : 24'hA5A5A5, 8'h48};
    ram[BASE + 1] = {24'h123456, 8'h45};
    ram[BASE + 2] = {24'h000000, hello[15:8]};
    ram[BASE + 3] = {24'hABCDEF, hello[7:0] - 8'h03};
    ram[BASE + 4] = {24'h7F7F7F, hello[7:0]};

    @(negedge clock);
    @(negedge clock);
    check_idle("reset");
    reset = 1'b1;
    @(negedge clock);

    run_drain("hello", 7'd5, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    run_drain("clamp", 7'd120, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    run_drain("stall", 7'd3, 4, 1'b1, 0, 0, 1'b0, 1'b0);
    run_drain("zero", 7'd0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    run_drain("abort", 7'd6, 0, 1'b0, 1, 2, 1'b0, 1'b0);
    run_drain("post abort", 7'd4, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    run_drain("rst", 7'd6, 1, 1'b1, 2, 2, 1'b0, 1'b0);
    run_drain("post rst", 7'd4, 0, 1'b0, 0, 0, 1'b0, 1'b1);

    start = 1'b1; abort = 1'b1; char_count = 7'd5;
    cyc();
    start = 1'b0; abort = 1'b0;
    check_idle("start+abort");
    cyc();
    check_idle("start+abort next");

    for (int i = 0; i < 40; i++) ram[BASE + i][31:8] = 24'hFF_FFFF;
    run_drain("restart", 7'd20, 0, 1'b1, 0, 0, 1'b1, 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 120; i++) ram[BASE + i] = $urandom;
      rc = 7'($urandom_range(1, 127));
      run_drain("random", rc, int'($urandom_range(0, 3)), 1'($urandom), 0, 0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
